// File: rtl/onehot_req_encoder_if.sv
// onehot_req_encoder_if: request strobes in, valid/ready index stream and status out
interface onehot_req_encoder_if;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic       busy;
    modport master (output req, out_ready, input out_valid, out_idx, pending, busy);
    modport slave  (input req, out_ready, output out_valid, out_idx, pending, busy);
endinterface

// File: rtl/onehot_req_encoder.sv
// onehot_req_encoder: sticky request collector emitting 3-bit indices via valid/ready; ONEHOT_REQ_ENCODER_ROUND_ROBIN_EN selects round-robin over fixed-lowest priority
module onehot_req_encoder (
    input logic                 clk,
    input logic                 rst,
    onehot_req_encoder_if.slave bus
);
    logic [7:0] pend;
    logic       valid;
    logic [2:0] idx;
    logic       load;
    logic       hit;
    logic [2:0] g;
    logic [7:0] grant_mask;
    assign load       = !valid || bus.out_ready;
    assign hit        = |pend;
    assign grant_mask = (load && hit) ? 8'b1 << g : 8'b0;
`ifdef ONEHOT_REQ_ENCODER_ROUND_ROBIN_EN
    logic [2:0]  last_idx;
    logic [2:0]  start;
    logic [15:0] rot;
    assign start = last_idx + 3'd1;
    // bit i of rot is pend[(start + i) mod 8]
    assign rot   = {pend, pend} >> start;
    always_comb begin
        g = start;
        for (int i = 7; i >= 0; i--)
            if (rot[i]) g = start + 3'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) last_idx <= 3'd7;
        else if (load && hit) last_idx <= g;
    end
`else
    always_comb begin
        g = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (pend[i]) g = 3'(i);
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= 8'h00;
            valid <= 1'b0;
            idx   <= 3'd0;
        end else begin
            pend <= (pend & ~grant_mask) | bus.req;
            if (load) valid <= hit;
            if (load && hit) idx <= g;
        end
    end
    assign bus.out_valid = valid;
    assign bus.out_idx   = idx;
    assign bus.pending   = pend;
    assign bus.busy      = hit || valid;
endmodule

// File: tb/tb_onehot_req_encoder.sv
// tb_onehot_req_encoder: random and directed checks against a behavioural model of the encoder
module tb_onehot_req_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic started = 1'b0;
    int   total = 0;
    int   bad = 0;
    onehot_req_encoder_if bus ();
    onehot_req_encoder dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [7:0] m_pend = 8'h00;
    logic       m_valid = 1'b0;
    logic [2:0] m_idx = 3'd0;
    int         m_last = 7;
    function automatic int pick(input logic [7:0] p, input int last);
`ifdef ONEHOT_REQ_ENCODER_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++)
            if (p[(last + k) % 8]) return (last + k) % 8;
`else
        for (int j = 0; j < 8; j++)
            if (p[j]) return j;
`endif
        return -1;
    endfunction
    always @(posedge clk) begin
        automatic int         g = pick(m_pend, m_last);
        automatic bit         ld = !m_valid || bus.out_ready;
        automatic logic [7:0] nxt = m_pend;
        if (rst) begin
            m_pend  <= 8'h00;
            m_valid <= 1'b0;
            m_idx   <= 3'd0;
            m_last  <= 7;
        end else begin
            if (ld && g >= 0) nxt[g] = 1'b0;
            m_pend <= nxt | bus.req;
            if (ld) m_valid <= (g >= 0);
            if (ld && g >= 0) begin
                m_idx  <= 3'(g);
                m_last <= g;
            end
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (started) begin
            chk("model_valid", int'(bus.out_valid), int'(m_valid));
            chk("model_idx", int'(bus.out_idx), int'(m_idx));
            chk("model_pending", int'(bus.pending), int'(m_pend));
            chk("model_busy", int'(bus.busy), int'(m_pend != 8'h00 || m_valid));
        end
    end
    task automatic tick(input logic [7:0] r, input logic rd);
        bus.req = r;
        bus.out_ready = rd;
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(8'hFF, 1'b1);
            started = 1'b1;
            chk("rst_pending", int'(bus.pending), 0);
            chk("rst_valid", int'(bus.out_valid), 0);
            chk("rst_idx", int'(bus.out_idx), 0);
            chk("rst_busy", int'(bus.busy), 0);
        end
        rst = 1'b0;
    endtask
    initial begin
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
        do_reset();
        // single pulse: index appears two cycles after the strobe, for one cycle
        tick(8'h20, 1'b1);
        chk("single_pend", int'(bus.pending), 8'h20);
        chk("single_early", int'(bus.out_valid), 0);
        tick(8'h00, 1'b1);
        chk("single_valid", int'(bus.out_valid), 1);
        chk("single_idx", int'(bus.out_idx), 5);
        chk("single_busy", int'(bus.busy), 1);
        tick(8'h00, 1'b1);
        chk("single_drop", int'(bus.out_valid), 0);
        chk("single_idle", int'(bus.busy), 0);
        do_reset();
        tick(8'h8A, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(8'h00, 1'b1);
            chk("drain_valid", int'(bus.out_valid), 1);
            chk("drain_idx", int'(bus.out_idx), k == 0 ? 1 : k == 1 ? 3 : 7);
        end
        do_reset();
        tick(8'h06, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(8'h00, 1'b0);
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_idx", int'(bus.out_idx), 1);
            chk("bp_pend", int'(bus.pending), 8'h04);
        end
        tick(8'h00, 1'b1);
        chk("bp_next", int'(bus.out_idx), 2);
        do_reset();
`ifdef ONEHOT_REQ_ENCODER_ROUND_ROBIN_EN
        tick(8'h11, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(8'h11, 1'b1);
            chk("rereq_pend0", int'(bus.pending[0]), 1);
            chk("rereq_idx", int'(bus.out_idx), (k % 2 == 0) ? 0 : 4);
        end
        do_reset();
        tick(8'hFF, 1'b1);
        for (int k = 0; k < 9; k++) begin
            tick(8'hFF, 1'b1);
            chk("fair_idx", int'(bus.out_idx), k % 8);
        end
`else
        tick(8'h01, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(8'h01, 1'b1);
            chk("rereq_pend0", int'(bus.pending[0]), 1);
            chk("rereq_idx", int'(bus.out_idx), 0);
            chk("rereq_valid", int'(bus.out_valid), 1);
        end
`endif
        tick(8'h00, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            tick(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00, 1'($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        for (int n = 0; n < 12; n++) tick(8'h00, 1'b1);
        chk("final_idle", int'(bus.busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
